lbm_collider_seq: RTL and testbench

Parametrised, sequential D2Q9 BGK collision unit for the lattice-Boltzmann datapath. Accepts one cell (nine populations plus relaxation rate) over a valid/ready handshake, computes rho, velocity by multi-cycle restoring division, the rho-weighted equilibrium and the relaxed populations, and presents the result on a second valid/ready interface. Sits between the streaming/fetch stage and the write-back stage. Adds per-cell bounce-back mode, saturation and divide-by-zero handling.

---
 rtl/lbm_collider_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_lbm_collider_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lbm_collider_seq.sv
// lbm_collider_seq: sequential D2Q9 BGK collision unit with bounce-back walls.
// One cell in flight; velocity comes from two radix-2 restoring dividers.
module lbm_collider_seq #(
    parameter int W    = 16,
    parameter int FRAC = 13
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [9*W-1:0] f_in,
    input  logic [W-1:0]   omega,
    input  logic           solid,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [9*W-1:0] f_out,
    output logic [W-1:0]   rho,
    output logic [W-1:0]   u_x,
    output logic [W-1:0]   u_y,
    output logic           div0,
    output logic           busy
);
    localparam int DW = W + FRAC;
    localparam int WX = 2 * W + 16;
    localparam int CW = $clog2(DW + 1);

    localparam logic signed [WX-1:0] ONE  = WX'(2 ** FRAC);
    localparam logic signed [WX-1:0] WT0  = WX'(((4 << FRAC) + 4) / 9);
    localparam logic signed [WX-1:0] WT1  = WX'(((1 << FRAC) + 4) / 9);
    localparam logic signed [WX-1:0] WT2  = WX'(((1 << FRAC) + 18) / 36);
    localparam logic signed [WX-1:0] K3   = WX'(3);
    localparam logic signed [WX-1:0] K9   = WX'(9);
    localparam logic signed [WX-1:0] SMAX = WX'(2 ** (W - 1) - 1);
    localparam logic signed [WX-1:0] SMIN = -SMAX - WX'(1);
    localparam logic [DW-1:0]        QPOS = DW'(2 ** (W - 1) - 1);
    localparam logic [DW-1:0]        QNEG = DW'(2 ** (W - 1));

    typedef enum logic [2:0] {IDLE, DIV, EQ, RELAX, OUT} state_t;

    function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
        return v[W-1] ? -v : v;
    endfunction

    function automatic logic signed [W-1:0] uq(input logic [DW-1:0] q,
                                               input logic neg);
        if (neg) begin
            if (q >= QNEG) return {1'b1, {(W - 1){1'b0}}};
            return -q[W-1:0];
        end
        if (q > QPOS) return {1'b0, {(W - 1){1'b1}}};
        return q[W-1:0];
    endfunction

    // c_k . u for slot order null,n,ne,e,se,s,sw,w,nw
    function automatic logic signed [WX-1:0] cdot(input int k,
                                                  input logic signed [WX-1:0] x,
                                                  input logic signed [WX-1:0] y);
        case (k)
            1:       return y;
            2:       return x + y;
            3:       return x;
            4:       return x - y;
            5:       return -y;
            6:       return -(x + y);
            7:       return -x;
            8:       return y - x;
            default: return '0;
        endcase
    endfunction

    function automatic logic signed [WX-1:0] wgt(input int k);
        if (k == 0) return WT0;
        if (k % 2 == 1) return WT1;
        return WT2;
    endfunction

    function automatic int opp(input int k);
        if (k == 0) return 0;
        return (k < 5) ? k + 4 : k - 4;
    endfunction

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic signed [W-1:0]    f_q [9];
    logic signed [W-1:0]    om_q;
    logic                   solid_q;
    logic signed [W-1:0]    rho_q;
    logic                   dz;
    logic                   neg_x, neg_y;
    logic [DW-1:0]          dvd_x, dvd_y;
    logic [W-1:0]           rem_x, rem_y;
    logic signed [WX-1:0]   feq_q [9];

    logic signed [W-1:0]    sum_c, mx_c, my_c;
    logic [W:0]             sh_x, sh_y;
    logic                   ge_x, ge_y;
    logic [W-1:0]           nrem_x, nrem_y;
    logic signed [W-1:0]    ux_c, uy_c;
    logic signed [WX-1:0]   uxw, uyw, rhow, omw, usq;
    logic signed [WX-1:0]   cu_c [9];
    logic signed [WX-1:0]   cu2_c [9];
    logic signed [WX-1:0]   poly_c [9];
    logic signed [WX-1:0]   wr_c [9];
    logic signed [WX-1:0]   feq_c [9];
    logic signed [WX-1:0]   fw_c [9];
    logic signed [WX-1:0]   rel_c [9];
    logic signed [WX-1:0]   sm_c [9];
    logic signed [W-1:0]    fo_c [9];

    always_comb begin
        sum_c = '0;
        for (int k = 0; k < 9; k++) sum_c = sum_c + f_q[k];
        mx_c = f_q[3] - f_q[7] + f_q[2] - f_q[6] + f_q[4] - f_q[8];
        my_c = f_q[1] - f_q[5] + f_q[2] - f_q[6] + f_q[8] - f_q[4];
    end

    always_comb begin
        sh_x   = {rem_x, dvd_x[DW-1]};
        sh_y   = {rem_y, dvd_y[DW-1]};
        ge_x   = sh_x >= {1'b0, rho_q};
        ge_y   = sh_y >= {1'b0, rho_q};
        nrem_x = ge_x ? W'(sh_x - {1'b0, rho_q}) : sh_x[W-1:0];
        nrem_y = ge_y ? W'(sh_y - {1'b0, rho_q}) : sh_y[W-1:0];
        ux_c   = dz ? '0 : uq(dvd_x, neg_x);
        uy_c   = dz ? '0 : uq(dvd_y, neg_y);
    end

    // every product is kept full width, then truncated by FRAC
    always_comb begin
        uxw  = WX'(ux_c);
        uyw  = WX'(uy_c);
        rhow = WX'(rho_q);
        omw  = WX'(om_q);
        usq  = ((uxw * uxw) >>> FRAC) + ((uyw * uyw) >>> FRAC);
        for (int k = 0; k < 9; k++) begin
            cu_c[k]   = cdot(k, uxw, uyw);
            cu2_c[k]  = (cu_c[k] * cu_c[k]) >>> FRAC;
            poly_c[k] = ONE + K3 * cu_c[k] + ((K9 * cu2_c[k]) >>> 1)
                        - ((K3 * usq) >>> 1);
            wr_c[k]   = (wgt(k) * rhow) >>> FRAC;
            feq_c[k]  = (wr_c[k] * poly_c[k]) >>> FRAC;
        end
    end

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            fw_c[k]  = WX'(f_q[k]);
            rel_c[k] = (omw * (feq_q[k] - fw_c[k])) >>> FRAC;
            sm_c[k]  = fw_c[k] + rel_c[k];
            if (solid_q) fo_c[k] = f_q[opp(k)];
            else if (sm_c[k] > SMAX) fo_c[k] = W'(SMAX);
            else if (sm_c[k] < SMIN) fo_c[k] = W'(SMIN);
            else fo_c[k] = sm_c[k][W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            om_q      <= '0;
            solid_q   <= 1'b0;
            rho_q     <= '0;
            dz        <= 1'b0;
            neg_x     <= 1'b0;
            neg_y     <= 1'b0;
            dvd_x     <= '0;
            dvd_y     <= '0;
            rem_x     <= '0;
            rem_y     <= '0;
            for (int k = 0; k < 9; k++) begin
                f_q[k]   <= '0;
                feq_q[k] <= '0;
            end
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            f_out     <= '0;
            rho       <= '0;
            u_x       <= '0;
            u_y       <= '0;
            div0      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    for (int k = 0; k < 9; k++) f_q[k] <= f_in[k*W +: W];
                    om_q     <= omega;
                    solid_q  <= solid;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    state    <= DIV;
                end
                DIV: begin
                    // first DIV cycle loads the moments, then DW quotient bits
                    if (cnt == '0) begin
                        rho_q <= sum_c;
                        dz    <= sum_c[W-1] || (sum_c == '0);
                        neg_x <= mx_c[W-1];
                        neg_y <= my_c[W-1];
                        dvd_x <= {mag(mx_c), {FRAC{1'b0}}};
                        dvd_y <= {mag(my_c), {FRAC{1'b0}}};
                        rem_x <= '0;
                        rem_y <= '0;
                    end else begin
                        dvd_x <= {dvd_x[DW-2:0], ge_x};
                        dvd_y <= {dvd_y[DW-2:0], ge_y};
                        rem_x <= nrem_x;
                        rem_y <= nrem_y;
                    end
                    if (cnt == CW'(DW)) state <= EQ;
                    cnt <= cnt + 1'b1;
                end
                EQ: begin
                    for (int k = 0; k < 9; k++) feq_q[k] <= feq_c[k];
                    state <= RELAX;
                end
                RELAX: begin
                    for (int k = 0; k < 9; k++) f_out[k*W +: W] <= fo_c[k];
                    rho       <= rho_q;
                    u_x       <= ux_c;
                    u_y       <= uy_c;
                    div0      <= dz;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lbm_collider_seq.sv
// tb_lbm_collider_seq: directed and random cells against a D2Q9 BGK model.
// Model works on velocity vectors and native integer division.
module tb_lbm_collider_seq;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst, in_valid, in_ready, solid;
    logic           out_valid, out_ready, div0, busy;
    logic [9*W-1:0] f_in, f_out;
    logic [W-1:0]   omega, rho, u_x, u_y;

    int total = 0;
    int bad   = 0;

    int CX [9] = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
    int CY [9] = '{0, 1, 1, 0, -1, -1, -1, 0, 1};
    int WT [9] = '{3641, 910, 228, 910, 228, 910, 228, 910, 228};
    int REST [9] = '{'h0E39, 'h038E, 'h00E4, 'h038E, 'h00E4,
                     'h038E, 'h00E4, 'h038E, 'h00E4};

    int  m_fo [9];
    int  m_rho, m_ux, m_uy;
    bit  m_dz;

    always #5 clk = ~clk;

    lbm_collider_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .f_in(f_in), .omega(omega), .solid(solid), .out_valid(out_valid),
        .out_ready(out_ready), .f_out(f_out), .rho(rho), .u_x(u_x),
        .u_y(u_y), .div0(div0), .busy(busy)
    );

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int s16(input longint v);
        logic [15:0] t;
        t = v[15:0];
        return int'($signed(t));
    endfunction

    function automatic int fo_of(input int k);
        return int'($signed(f_out[k*W +: W]));
    endfunction

    function automatic longint udiv(input longint m, input longint r);
        longint q;
        q = ((m < 0 ? -m : m) << 13) / r;
        if (m < 0) q = -q;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    task automatic model(input int f [9], input int om, input bit sol);
        longint s, mx, my, ux, uy, usq, cu, cu2, poly, wr, feq, v;
        s = 0; mx = 0; my = 0;
        for (int k = 0; k < 9; k++) begin
            s  += f[k];
            mx += CX[k] * f[k];
            my += CY[k] * f[k];
        end
        m_rho = s16(s);
        mx = s16(mx);
        my = s16(my);
        m_dz = (m_rho <= 0);
        ux = m_dz ? 0 : udiv(mx, m_rho);
        uy = m_dz ? 0 : udiv(my, m_rho);
        m_ux = int'(ux);
        m_uy = int'(uy);
        usq = ((ux * ux) >>> 13) + ((uy * uy) >>> 13);
        for (int k = 0; k < 9; k++) begin
            if (sol) begin
                for (int j = 0; j < 9; j++)
                    if (CX[j] == -CX[k] && CY[j] == -CY[k]) m_fo[k] = f[j];
            end else begin
                cu   = CX[k] * ux + CY[k] * uy;
                cu2  = (cu * cu) >>> 13;
                poly = 8192 + 3 * cu + ((9 * cu2) >>> 1) - ((3 * usq) >>> 1);
                wr   = (WT[k] * longint'(m_rho)) >>> 13;
                feq  = (wr * poly) >>> 13;
                v    = f[k] + ((om * (feq - f[k])) >>> 13);
                if (v > 32767) v = 32767;
                if (v < -32768) v = -32768;
                m_fo[k] = int'(v);
            end
        end
    endtask

    task automatic send_cell(input int f [9], input int om, input bit sol,
                             input string tag);
        bit acc = 0;
        int n = 0;
        for (int k = 0; k < 9; k++) f_in[k*W +: W] = f[k][15:0];
        omega = om[15:0];
        solid = sol;
        in_valid = 1'b1;
        while (!acc && n < 50) begin
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        chk({tag, "_accept"}, acc, 1);
    endtask

    task automatic collect(input int f [9], input int om, input bit sol,
                           input string tag);
        int lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 32);
        model(f, om, sol);
        chk({tag, "_rho"}, rho, m_rho & 'hFFFF);
        chk({tag, "_ux"}, u_x, m_ux & 'hFFFF);
        chk({tag, "_uy"}, u_y, m_uy & 'hFFFF);
        chk({tag, "_div0"}, div0, m_dz);
        for (int k = 0; k < 9; k++)
            chk($sformatf("%s_fo%0d", tag, k), f_out[k*W +: W],
                m_fo[k] & 'hFFFF);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_rel_ovalid"}, out_valid, 0);
        chk({tag, "_rel_iready"}, in_ready, 1);
    endtask

    initial begin
        int f [9];
        int g [9];
        int om, hits, d;
        bit sol;
        logic [9*W+3*W+1:0] held;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; solid = 1'b0;
        f_in = '0; omega = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_iready", in_ready, 1);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_div0", div0, 0);
        chk("rst_fout", f_out, 0);
        chk("rst_moments", {rho, u_x, u_y}, 0);

        f = REST;
        send_cell(f, 'h2000, 0, "rest");
        collect(f, 'h2000, 0, "rest");
        for (int k = 0; k < 9; k++) begin
            d = fo_of(k) - f[k];
            chk($sformatf("rest_near%0d", k), (d <= 2 && d >= -2), 1);
        end
        release_out("rest");

        f = REST;
        f[3] += 'h100;
        send_cell(f, 'h2000, 0, "rstdiv");
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rstdiv_iready", in_ready, 1);
        chk("rstdiv_busy", busy, 0);
        chk("rstdiv_outs", {f_out, rho, u_x, u_y, div0, out_valid}, 0);
        hits = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) hits++;
        end
        chk("rstdiv_no_output", hits, 0);

        send_cell(f, 'h2000, 0, "flow");
        collect(f, 'h2000, 0, "flow");
        chk("flow_e_gt_w", fo_of(3) > fo_of(7), 1);
        chk("flow_div0", div0, 0);
        release_out("flow");

        f = '{0, 'h0100, 'h0011, 0, 0, 'h0200, 'h0022, 0, 0};
        send_cell(f, 'h2000, 1, "bounce");
        collect(f, 'h2000, 1, "bounce");
        chk("bounce_n", f_out[1*W +: W], 'h0200);
        chk("bounce_s", f_out[5*W +: W], 'h0100);
        chk("bounce_ne", f_out[2*W +: W], 'h0022);
        chk("bounce_sw", f_out[6*W +: W], 'h0011);
        release_out("bounce");

        f = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_cell(f, 'h2000, 0, "zero");
        collect(f, 'h2000, 0, "zero");
        chk("zero_div0", div0, 1);
        chk("zero_all", {f_out, rho, u_x, u_y}, 0);
        release_out("zero");

        f = '{0, 0, 0, 'h4000, 0, 0, 0, -'h3FF0, 0};
        send_cell(f, 'h1800, 0, "sat");
        collect(f, 'h1800, 0, "sat");
        chk("sat_ux", u_x, 'h7FFF);
        release_out("sat");

        for (int k = 0; k < 9; k++)
            f[k] = REST[k] + int'($urandom_range(0, 512)) - 256;
        send_cell(f, 'h1C00, 0, "bp");
        collect(f, 'h1C00, 0, "bp");
        held = {f_out, rho, u_x, u_y, div0, out_valid};
        g = REST;
        for (int k = 0; k < 9; k++) f_in[k*W +: W] = g[k][15:0];
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d", c),
                {f_out, rho, u_x, u_y, div0, out_valid}, held);
            chk($sformatf("bp_stall%0d", c), {in_ready, busy}, 2'b01);
        end
        release_out("bp");
        send_cell(g, 'h2000, 0, "after_bp");
        collect(g, 'h2000, 0, "after_bp");
        release_out("after_bp");

        for (int i = 0; i < 24; i++) begin
            if (i % 4 == 3) begin
                for (int k = 0; k < 9; k++) f[k] = s16($urandom());
                om = s16($urandom());
            end else begin
                for (int k = 0; k < 9; k++)
                    f[k] = REST[k] + int'($urandom_range(0, 1024)) - 512;
                om = int'($urandom_range('h0800, 'h3800));
            end
            sol = ($urandom_range(0, 3) == 0);
            send_cell(f, om, sol, $sformatf("rnd%0d", i));
            collect(f, om, sol, $sformatf("rnd%0d", i));
            release_out($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
